// File: rtl/img_window_fetch_if.sv
// img_window_fetch_if
//   Image-memory read port used by img_window_fetch.
//   master (fetch stage): drives mem_addr / mem_rd_en, samples mem_data.
//   slave  (memory)     : samples mem_addr / mem_rd_en, drives mem_data.
//   mem_data is valid MEM_LAT cycles after the registered address/strobe.
interface img_window_fetch_if #(
    parameter int unsigned ADDR_W = 19
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_data;

    modport master (
        output mem_addr,
        output mem_rd_en,
        input  mem_data
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        output mem_data
    );
endinterface

// File: rtl/img_window_fetch.sv
// img_window_fetch
//   Per-pixel image fetch between the VGA timing generator and the grey
//   output. Maps the raster position to an image-memory read address with
//   the image anchored top-left at 1x or 2x nearest-neighbour zoom, delays
//   sync/active to match the memory latency and blanks pixels outside the
//   image window.
//
// Ports
//   clk, reset          pixel clock, asynchronous active-high reset
//   pix_x, pix_y        raster column / row
//   active              raster inside the visible area
//   hs_in, vs_in        syncs (active-low)
//   dimensiones         [15:8] image width, [7:0] image height
//   zoom                0 = 1x, 1 = 2x
//   mem                 image-memory read port (master side)
//   pixel               grey output pixel
//   pixel_valid         delayed active
//   hs_out, vs_out      delayed syncs
//
// Build option
//   IMG_BORDER_EN       when defined, draws a white 1-pixel frame (2 pixels
//                       at 2x zoom) just right of / below the image.
module img_window_fetch #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned MEM_LAT  = 2,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [9:0]                pix_x,
    input  logic [9:0]                pix_y,
    input  logic                      active,
    input  logic                      hs_in,
    input  logic                      vs_in,
    input  logic [15:0]               dimensiones,
    input  logic                      zoom,
    img_window_fetch_if.master        mem,
    output logic [7:0]                pixel,
    output logic                      pixel_valid,
    output logic                      hs_out,
    output logic                      vs_out
);

    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

    typedef enum logic {
        WAIT_FRAME,
        SCAN
    } state_t;

    state_t state, state_nxt;
    logic   scan_en;

    logic [7:0] w_sh, h_sh;
    logic       z_sh;
    logic [7:0] w_cur, h_cur;
    logic       z_cur;

    logic       fs;
    logic       on_screen;
    logic       line_start;
    logic [9:0] xz, yz;
    logic       in_win;
    logic       border;

    logic [ADDR_W-1:0] row_base, row_cur, rd_addr;
    logic [7:0]        col, col_cur;
    logic              col_inc;

    logic [MEM_LAT:0] win_d, brd_d, act_d, hs_d, vs_d;

    assign fs         = active && (pix_x == '0) && (pix_y == '0);
    assign on_screen  = active && (pix_x < H_LIM) && (pix_y < V_LIM);
    assign line_start = active && (pix_x == '0);

    // The frame-start pixel itself must already use the new dimensions,
    // so the shadow registers are bypassed on that cycle.
    assign w_cur = fs ? dimensiones[15:8] : w_sh;
    assign h_cur = fs ? dimensiones[7:0]  : h_sh;
    assign z_cur = fs ? zoom              : z_sh;

    assign xz = z_cur ? {1'b0, pix_x[9:1]} : pix_x;
    assign yz = z_cur ? {1'b0, pix_y[9:1]} : pix_y;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_FRAME;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scan_en   = 1'b0;
        case (state)
            WAIT_FRAME: begin
                if (fs) begin
                    state_nxt = SCAN;
                    scan_en   = 1'b1;
                end
            end
            SCAN: begin
                scan_en = 1'b1;
            end
            default: begin
                state_nxt = WAIT_FRAME;
            end
        endcase
    end

    // ---------------- window / border ----------------
    assign in_win = scan_en && on_screen
                 && (xz < {2'b00, w_cur}) && (yz < {2'b00, h_cur});

`ifdef IMG_BORDER_EN
    assign border = scan_en && on_screen && !in_win
                 && (w_cur != '0) && (h_cur != '0)
                 && (((xz == {2'b00, w_cur}) && (yz <= {2'b00, h_cur}))
                  || ((yz == {2'b00, h_cur}) && (xz <= {2'b00, w_cur})));
`else
    assign border = 1'b0;
`endif

    // ---------------- shadow registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_sh <= '0;
            h_sh <= '0;
            z_sh <= 1'b0;
        end else if (fs) begin
            w_sh <= dimensiones[15:8];
            h_sh <= dimensiones[7:0];
            z_sh <= zoom;
        end
    end

    // ---------------- address generation ----------------
    // row_cur/col_cur are the base and column of the current pixel; the
    // registers hold the values carried into the next pixel. The row base
    // only advances when entering a new image row that lies in the window,
    // which keeps the accumulator within 255*254.
    always_comb begin
        row_cur = row_base;
        col_cur = col;
        if (line_start) begin
            col_cur = '0;
            if (pix_y == '0) begin
                row_cur = '0;
            end else if ((!z_cur || !pix_y[0]) && (yz < {2'b00, h_cur})) begin
                row_cur = row_base + ADDR_W'(w_cur);
            end
        end
    end

    assign rd_addr = row_cur + ADDR_W'(col_cur);
    assign col_inc = in_win && (!z_cur || pix_x[0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_base <= '0;
            col      <= '0;
        end else begin
            row_base <= row_cur;
            col      <= col_inc ? col_cur + 8'd1 : col_cur;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem.mem_addr  <= '0;
            mem.mem_rd_en <= 1'b0;
        end else begin
            mem.mem_rd_en <= in_win;
            if (in_win) begin
                mem.mem_addr <= rd_addr;
            end
        end
    end

    // ---------------- delay line and output ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_d <= '0;
            brd_d <= '0;
            act_d <= '0;
            hs_d  <= '1;
            vs_d  <= '1;
        end else begin
            win_d <= {win_d[MEM_LAT-1:0], in_win};
            brd_d <= {brd_d[MEM_LAT-1:0], border};
            act_d <= {act_d[MEM_LAT-1:0], active};
            hs_d  <= {hs_d[MEM_LAT-1:0],  hs_in};
            vs_d  <= {vs_d[MEM_LAT-1:0],  vs_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel       <= '0;
            pixel_valid <= 1'b0;
            hs_out      <= 1'b1;
            vs_out      <= 1'b1;
        end else begin
            if (win_d[MEM_LAT]) begin
                pixel <= mem.mem_data;
            end else if (brd_d[MEM_LAT]) begin
                pixel <= 8'hFF;
            end else begin
                pixel <= 8'h00;
            end
            pixel_valid <= act_d[MEM_LAT];
            hs_out      <= hs_d[MEM_LAT];
            vs_out      <= vs_d[MEM_LAT];
        end
    end

endmodule

// File: tb/tb_img_window_fetch.sv
// tb_img_window_fetch
//   Scoreboard bench for img_window_fetch on a reduced raster (20x10 total,
//   12x7 visible). The driver computes each expected output from the image
//   geometry ((y>>z)*W + (x>>z)) and queues it; a monitor compares outputs
//   when their latency has elapsed, plus per-frame read-strobe counts and
//   reset values.
module tb_img_window_fetch;

    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned LAT     = MEM_LAT + 2;
    localparam int unsigned HT      = 20;
    localparam int unsigned VT      = 10;
    localparam int unsigned HA      = 12;
    localparam int unsigned VA      = 7;
    localparam int          NO_IDX  = 99999;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        active = 1'b0;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic [15:0] dimensiones = '0;
    logic        zoom = 1'b0;
    logic [7:0]  pixel;
    logic        pixel_valid;
    logic        hs_out;
    logic        vs_out;

    img_window_fetch_if #(.ADDR_W(ADDR_W)) mif ();

    img_window_fetch #(
        .H_ACTIVE (640),
        .V_ACTIVE (480),
        .MEM_LAT  (MEM_LAT),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .active      (active),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .dimensiones (dimensiones),
        .zoom        (zoom),
        .mem         (mif),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .hs_out      (hs_out),
        .vs_out      (vs_out)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory returns the low address byte; a distinct filler when not read.
    logic [7:0] mem_pipe [MEM_LAT];
    always @(posedge clk) begin
        mem_pipe[0] <= mif.mem_rd_en ? mif.mem_addr[7:0] : 8'hA5;
        for (int i = 1; i < int'(MEM_LAT); i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign mif.mem_data = mem_pipe[MEM_LAT-1];

    typedef struct {
        int unsigned t;
        logic [7:0]  pix;
        logic        v;
        logic        hs;
        logic        vs;
    } exp_t;

    typedef struct {
        int unsigned t;
        int unsigned n;
    } cnt_t;

    exp_t q[$];
    cnt_t cq[$];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned rd_cnt = 0;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        cnt_t c;
        if (reset) begin
            checks++;
            if (pixel !== 8'h00 || pixel_valid !== 1'b0 || hs_out !== 1'b1 ||
                vs_out !== 1'b1 || mif.mem_rd_en !== 1'b0 || mif.mem_addr !== '0) begin
                errors++;
                $display("FAIL reset_values: pixel=%h valid=%b hs=%b vs=%b rd_en=%b addr=%h, required 00 0 1 1 0 0",
                         pixel, pixel_valid, hs_out, vs_out, mif.mem_rd_en, mif.mem_addr);
            end
            rd_cnt = 0;
        end else begin
            while (q.size() > 0 && q[0].t + LAT < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_sample: stimulus cycle %0d never compared", e.t);
            end
            if (q.size() > 0 && q[0].t + LAT == cyc) begin
                e = q.pop_front();
                checks++;
                if (pixel !== e.pix || pixel_valid !== e.v || hs_out !== e.hs || vs_out !== e.vs) begin
                    errors++;
                    $display("FAIL output@%0d: pixel=%h valid=%b hs=%b vs=%b, required %h %b %b %b",
                             e.t, pixel, pixel_valid, hs_out, vs_out, e.pix, e.v, e.hs, e.vs);
                end
            end
            if (cq.size() > 0 && cq[0].t == cyc) begin
                c = cq.pop_front();
                checks++;
                if (rd_cnt != c.n) begin
                    errors++;
                    $display("FAIL rd_en_count: got %0d reads, required %0d", rd_cnt, c.n);
                end
                rd_cnt = 0;
            end
            if (mif.mem_rd_en) rd_cnt++;
        end
    end

    // ---------------- reference model state ----------------
    bit          started = 1'b0;
    int unsigned wl = 0, hl = 0, zl = 0;

    task automatic run_frame(input logic [15:0] d0, input logic z0,
                             input logic [15:0] d1, input logic z1,
                             input int chg_idx, input int rst_idx);
        int unsigned n = 0;
        for (int y = 0; y < int'(VT); y++) begin
            for (int x = 0; x < int'(HT); x++) begin
                int idx;
                int unsigned xz, yz;
                bit inwin, brd;
                exp_t e;
                idx = y * int'(HT) + x;
                @(posedge clk);
                if (idx == rst_idx) begin
                    #3;
                    reset = 1'b1;
                    q.delete();
                    started = 1'b0;
                    n = 0;
                end else begin
                    #1;
                end
                if (rst_idx >= 0 && idx == rst_idx + 3) reset = 1'b0;
                if (idx >= chg_idx) begin
                    dimensiones = d1;
                    zoom        = z1;
                end else begin
                    dimensiones = d0;
                    zoom        = z0;
                end
                pix_x  = 10'(x);
                pix_y  = 10'(y);
                active = (x < int'(HA)) && (y < int'(VA));
                hs_in  = !(x >= 14 && x < 16);
                vs_in  = (y != 8);
                if (!reset) begin
                    if (active && x == 0 && y == 0) begin
                        started = 1'b1;
                        wl = dimensiones[15:8];
                        hl = dimensiones[7:0];
                        zl = zoom;
                    end
                    xz = int'(x) >> zl;
                    yz = int'(y) >> zl;
                    inwin = started && active && xz < wl && yz < hl;
                    brd = 1'b0;
`ifdef IMG_BORDER_EN
                    brd = started && active && !inwin && wl != 0 && hl != 0 &&
                          ((xz == wl && yz <= hl) || (yz == hl && xz <= wl));
`endif
                    e.t   = cyc;
                    e.pix = inwin ? 8'(yz * wl + xz) : (brd ? 8'hFF : 8'h00);
                    e.v   = active;
                    e.hs  = hs_in;
                    e.vs  = vs_in;
                    q.push_back(e);
                    if (inwin) n++;
                end
            end
        end
        cq.push_back('{t: cyc + 2, n: n});
    endtask

    function automatic logic [7:0] rnd_dim(input int unsigned hi);
        if ($urandom_range(0, 9) == 0) return 8'd255;
        return 8'($urandom_range(0, hi));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;

        run_frame(16'h0403, 1'b0, 16'h0403, 1'b0, NO_IDX, -1);
        run_frame(16'h0403, 1'b0, 16'h0403, 1'b0, NO_IDX, -1);
        run_frame(16'h0403, 1'b1, 16'h0403, 1'b1, NO_IDX, -1);
        // mid-frame dimension change, then the new size on the next frame
        run_frame(16'h0403, 1'b0, 16'h0202, 1'b0, 70, -1);
        run_frame(16'h0202, 1'b0, 16'h0202, 1'b0, NO_IDX, -1);
        // zoom toggled mid-frame
        run_frame(16'h0403, 1'b0, 16'h0403, 1'b1, 30, -1);
        run_frame(16'h0005, 1'b0, 16'h0005, 1'b0, NO_IDX, -1);
        // reset mid-line, then black until the next frame start
        run_frame(16'h0403, 1'b0, 16'h0403, 1'b0, NO_IDX, 45);
        run_frame(16'h0403, 1'b0, 16'h0403, 1'b0, NO_IDX, -1);

        for (int f = 0; f < 10; f++) begin
            logic [15:0] d0, d1;
            logic        z0, z1;
            int          chg;
            d0  = {rnd_dim(14), rnd_dim(9)};
            d1  = {rnd_dim(14), rnd_dim(9)};
            z0  = 1'($urandom_range(0, 1));
            z1  = 1'($urandom_range(0, 1));
            chg = ($urandom_range(0, 2) == 0) ? NO_IDX : int'($urandom_range(0, HT * VT - 1));
            run_frame(d0, z0, d1, z1, chg, -1);
        end

        repeat (LAT + 4) @(posedge clk);
        #1;
        if (q.size() != 0 || cq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs and %0d counts pending, required 0 and 0", q.size(), cq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/img_window_fetch.md
# img_window_fetch

Per-pixel image fetch stage between the VGA timing generator and the grey-scale RGB output. It converts the raster position into a read address for the image memory and places the image at the top-left of the 640x480 screen, at 1x or 2x nearest-neighbour zoom. It delays the sync and active signals to match the memory read latency, and outputs an 8-bit grey pixel, forced to black outside the image window.

## Interface
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- MEM_LAT, 2, image-memory read latency in cycles (address registered → data valid), ≥1
- ADDR_W, 19, image-memory address width
- clk  in  1  pixel clock (25 MHz VGA clock)
- reset  in  1  asynchronous, active-high
- pix_x  in  10  current raster column from timing generator
- pix_y  in  10  current raster row
- active  in  1  raster inside visible area
- hs_in / vs_in  in  1 each  sync from timing generator (active-low)
- dimensiones  in  16  image size: [15:8] width W, [7:0] height H (pixels)
- zoom  in  1  0 = 1x, 1 = 2x replication
- mem_addr  out  ADDR_W  image-memory read address
- mem_rd_en  out  1  read strobe, high when mem_addr is a valid image pixel
- mem_data  in  8  pixel returned MEM_LAT cycles after mem_addr/mem_rd_en
- pixel  out  8  grey output pixel
- pixel_valid  out  1  delayed `active`
- hs_out / vs_out  out  1 each  delayed syncs

## Operation
- Frame start (FS) = active && pix_x==0 && pix_y==0. At FS, W, H and zoom are latched into shadow registers. Mid-frame changes are ignored until the next FS.
- FSM has two states:
  - WAIT_FRAME (after reset): mem_rd_en=0, pixel=0. Goes to SCAN at FS.
  - SCAN: stays in SCAN until reset.
- Window: in_win = active && (pix_x >> z) < W && (pix_y >> z) < H, where z is the latched zoom.
- No multiplier. A row_base accumulator (ADDR_W bits) and a col counter (8 bits) form address = row_base + col.
  - At pix_x==0 && active: col=0. If pix_y==0, row_base=0. Otherwise, when z==0 or pix_y[0]==0, row_base += W.
  - During in_win: col increments every pixel when z=0, and after odd pix_x when z=1.
- mem_addr and mem_rd_en are registered from in_win. When not in_win, mem_rd_en=0 and mem_addr holds its last value.
- A delay line of MEM_LAT+1 stages carries in_win, active, hs_in and vs_in.
- Output register: pixel = win_d ? mem_data : 8'h00. pixel_valid, hs_out and vs_out come from the last delay stage.
- W==0 or H==0: no window, mem_rd_en never asserted, pixel always 0.
- Windows wider or taller than the screen are clipped by `active`. The accumulator never exceeds 255·254 + 255 < 2^ADDR_W.

## Timing
- Reset values: mem_addr=0, mem_rd_en=0, pixel=0, pixel_valid=0, hs_out=1, vs_out=1. All delay stages cleared with syncs at 1, and FSM=WAIT_FRAME.
- Address path: raster inputs at cycle t → mem_addr/mem_rd_en at t+1.
- Output path: pixel/pixel_valid/hs_out/vs_out at t+MEM_LAT+2. Every output has identical latency, so sync-to-pixel alignment equals the input alignment.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous). After release, pixels stay black until the next FS.
- Zoom toggled mid-frame: takes effect at the next FS only.

## Configuration
- IMG_BORDER_EN defined: pixels just outside the window render as 8'hFF.
  - Border pixels are active with (pix_x>>z)==W and (pix_y>>z)≤H, or with (pix_y>>z)==H and (pix_x>>z)≤W.
  - This forms a 1-pixel frame (2 pixels at zoom=1).
  - The border pixel is computed at t and delayed with the other signals; it never asserts mem_rd_en.
- IMG_BORDER_EN undefined: everything outside the window is 8'h00.

## Test plan
- Reset mid-line, then release: all outputs equal their reset values at once. Outputs stay black until the first FS, then the first image pixel appears at the FS cycle + MEM_LAT+2.
- W=4, H=3, zoom=0, memory model returns data = addr[7:0]: line 0 shows 00,01,02,03 then 00. Line 2 starts with 08. Line 3 onward is all 00. mem_rd_en is high for exactly 12 cycles per frame.
- Same image with zoom=1: line 0 shows 00,00,01,01,…,03,03. Lines 0 and 1 are identical. Line 2 starts with 04,04. 48 reads per frame.
- dimensiones changed from 0x0403 to 0x0202 in the middle of frame N: frame N keeps a 4x3 window; frame N+1 uses 2x2.
- W=0: no mem_rd_en for a full frame, and pixel=0 throughout. hs_out and vs_out equal hs_in and vs_in delayed by exactly MEM_LAT+2.
- IMG_BORDER_EN build, W=4, H=3, zoom=0: pixel (4,0) = FF, pixel (0,3) = FF, pixel (4,3) = FF, pixel (5,0) = 00. Without the macro, all four are 00.
